// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
// Converts a 10-bit binary value to four BCD digits using a sequential
// shift-and-add-3 converter, then scans those digits onto a 4-digit
// common-segment display with optional leading-zero blanking.
// digit_code / digit_sel are decoded combinationally from registered state so
// that a display update shows on the current position right after its edge.

module bcd_scan_driver #(
    parameter int   SCAN_DIV      = 50000,
    parameter logic SEL_INVERT    = 1'b0,
    parameter logic BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] value,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit_code,
    output logic [3:0] digit_sel
);

    localparam int            PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO = PW'(0);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Add 3 to a single BCD nibble when it is 5 or more.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Apply the add-3 correction to all four nibbles of the accumulator.
    function automatic logic [15:0] adjust_bcd(input logic [15:0] bcd);
        return {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    endfunction

    state_t        state_r;
    logic [9:0]    shift_r;
    logic [15:0]   bcd_r;
    logic [3:0]    iter_r;
    logic [15:0]   disp_r;
    logic [PW-1:0] pre_r;
    logic [1:0]    idx_r;

    logic [15:0]   bcd_adj_s;
    logic [15:0]   bcd_next_s;
    logic          blank_s;
    logic [3:0]    sel_hi_s;

    // One converter iteration: correct nibbles, then shift in the next binary bit.
    always_comb begin
        bcd_adj_s  = adjust_bcd(bcd_r);
        bcd_next_s = {bcd_adj_s[14:0], shift_r[9]};
    end

    // Conversion FSM: accepts loads when idle, runs ten iterations, commits result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            shift_r <= 10'd0;
            bcd_r   <= 16'd0;
            iter_r  <= 4'd0;
            disp_r  <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        shift_r <= value;
                        bcd_r   <= 16'd0;
                        iter_r  <= 4'd0;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    shift_r <= {shift_r[8:0], 1'b0};
                    bcd_r   <= bcd_next_s;
                    iter_r  <= iter_r + 4'd1;
                    if (iter_r == 4'd9) begin
                        disp_r  <= bcd_next_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan prescaler and digit index; runs regardless of conversion activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= PRE_ZERO;
            idx_r <= 2'd0;
        end else if (pre_r == PRE_MAX) begin
            pre_r <= PRE_ZERO;
            idx_r <= idx_r + 2'd1;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    // Select the nibble for the scanned position and decide whether it is a leading zero.
    always_comb begin
        digit_code = 4'd0;
        blank_s    = 1'b0;
        case (idx_r)
            2'd0: begin
                digit_code = disp_r[3:0];
                blank_s    = 1'b0;
            end
            2'd1: begin
                digit_code = disp_r[7:4];
                blank_s    = (disp_r[15:4] == 12'd0);
            end
            2'd2: begin
                digit_code = disp_r[11:8];
                blank_s    = (disp_r[15:8] == 8'd0);
            end
            2'd3: begin
                digit_code = disp_r[15:12];
                blank_s    = (disp_r[15:12] == 4'd0);
            end
            default: begin
                digit_code = 4'd0;
                blank_s    = 1'b0;
            end
        endcase
    end

    // Build the one-hot digit enable, drop it for blanked positions, apply polarity.
    always_comb begin
        sel_hi_s = 4'b0000;
        if (BLANK_LEADING && blank_s) begin
            sel_hi_s = 4'b0000;
        end else begin
            sel_hi_s = 4'b0001 << idx_r;
        end
        if (SEL_INVERT) begin
            digit_sel = ~sel_hi_s;
        end else begin
            digit_sel = sel_hi_s;
        end
    end

endmodule
